hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
// Detects load-use (or, without forwarding, any RAW) hazards between the
// ID stage and the producers ahead of it, flushes on EX redirects, drains
// the pipeline after a Halt, and counts stall cycles.
// Optional feature: define HAZARD_FORWARD_EN to enable EX/MEM and MEM/WB
// operand forwarding; otherwise forwarding selects are tied to 00 and every
// EX/MEM producer match stalls the ID instruction.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic             ex_halt,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  // Drain counter holds DRAIN_CYCLES-1 down to 0.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e           state_q;
  logic [DW-1:0]    drain_cnt_q;
  logic             halted_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_hz;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  // A producer only matters when it really writes a non-x0 register that the
  // consumer really reads.
  function automatic logic src_match(input logic [4:0] rd, input logic we,
                                     input logic [4:0] src, input logic use_src);
    return use_src && we && (rd != 5'd0) && (rd == src);
  endfunction

`ifdef HAZARD_FORWARD_EN
  // With forwarding, only a load in EX cannot be bypassed in time.
  assign stall_hz = ex_memread &&
                    (src_match(ex_rd, ex_regwrite, id_rs1, id_use_rs1) ||
                     src_match(ex_rd, ex_regwrite, id_rs2, id_use_rs2));

  // The younger EX/MEM result wins over the older MEM/WB result.
  assign fwd_a_raw = src_match(mem_rd, mem_regwrite, ex_rs1, 1'b1) ? 2'b10 :
                     src_match(wb_rd,  wb_regwrite,  ex_rs1, 1'b1) ? 2'b01 : 2'b00;
  assign fwd_b_raw = src_match(mem_rd, mem_regwrite, ex_rs2, 1'b1) ? 2'b10 :
                     src_match(wb_rd,  wb_regwrite,  ex_rs2, 1'b1) ? 2'b01 : 2'b00;
`else
  // Without forwarding, ID waits until producers in EX and MEM reach WB;
  // the write-before-read register file covers the WB producer.
  assign stall_hz = src_match(ex_rd,  ex_regwrite,  id_rs1, id_use_rs1) ||
                    src_match(ex_rd,  ex_regwrite,  id_rs2, id_use_rs2) ||
                    src_match(mem_rd, mem_regwrite, id_rs1, id_use_rs1) ||
                    src_match(mem_rd, mem_regwrite, id_rs2, id_use_rs2);
  assign fwd_a_raw = 2'b00;
  assign fwd_b_raw = 2'b00;

  // Operand and WB fields only feed the forwarding network.
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_regwrite};
`endif

  // Pipeline control: halt beats redirect, redirect beats stall.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    fwd_a          = 2'b00;
    fwd_b          = 2'b00;
    if (!reset) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (state_q != S_RUN || ex_halt) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
      end else if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (stall_hz) begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_flush    = 1'b1;
      end
    end
  end

  // Run/drain/halt sequencing with a registered halted flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ex_halt) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= DRAIN_LOAD;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q - DW'(1);
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_RUN;
      endcase
    end
  end

  // Saturating count of RUN cycles lost to a stall that no redirect overrode.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_RUN && stall_hz && !ex_redirect && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Two instances share the stimulus: the
// default configuration and a small one (DRAIN_CYCLES=1, CNT_W=2) that makes
// counter saturation and short drains reachable quickly.
module tb_hazard_ctrl;

  localparam int D_BIG   = 3;
  localparam int D_SMALL = 1;
  localparam int W_SMALL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, ex_halt;
  logic       ex_redirect, mem_regwrite, wb_regwrite;

  logic        b_pc, b_ifid, b_iff, b_idf, b_halted;
  logic [1:0]  b_fa, b_fb;
  logic [15:0] b_cnt;
  logic        s_pc, s_ifid, s_iff, s_idf, s_halted;
  logic [1:0]  s_fa, s_fb;
  logic [W_SMALL-1:0] s_cnt;

  hazard_ctrl u_dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_halt(ex_halt),
    .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write_en(b_pc), .if_id_write_en(b_ifid), .if_id_flush(b_iff), .id_ex_flush(b_idf),
    .fwd_a(b_fa), .fwd_b(b_fb), .halted(b_halted), .stall_cnt(b_cnt)
  );

  hazard_ctrl #(.DRAIN_CYCLES(D_SMALL), .CNT_W(W_SMALL)) u_small (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_halt(ex_halt),
    .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_write_en(s_pc), .if_id_write_en(s_ifid), .if_id_flush(s_iff), .id_ex_flush(s_idf),
    .fwd_a(s_fa), .fwd_b(s_fb), .halted(s_halted), .stall_cnt(s_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "has a Halt been accepted since reset, and how many edges
  // ago", plus the two stall tallies.
  bit halt_seen = 0;
  int since     = 0;
  int cnt_big   = 0;
  int cnt_small = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit producer_hits(input logic [4:0] rd, input logic we,
                                       input logic [4:0] src, input logic rd_used);
    return rd_used && we && rd != 0 && rd == src;
  endfunction

  function automatic bit model_stall();
    bit ex_hit, mem_hit;
    ex_hit  = producer_hits(ex_rd, ex_regwrite, id_rs1, id_use_rs1) ||
              producer_hits(ex_rd, ex_regwrite, id_rs2, id_use_rs2);
    mem_hit = producer_hits(mem_rd, mem_regwrite, id_rs1, id_use_rs1) ||
              producer_hits(mem_rd, mem_regwrite, id_rs2, id_use_rs2);
`ifdef HAZARD_FORWARD_EN
    return ex_memread && ex_hit;
`else
    return ex_hit || mem_hit;
`endif
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef HAZARD_FORWARD_EN
    if (producer_hits(mem_rd, mem_regwrite, src, 1'b1)) return 2'b10;
    if (producer_hits(wb_rd, wb_regwrite, src, 1'b1))   return 2'b01;
`endif
    return 2'b00;
  endfunction

  // One clock: check combinational outputs, clock, update model, check state.
  task automatic run_cycle(input string tag);
    logic [3:0] e_ctl;  // {pc, ifid, if_flush, idex_flush}
    logic [1:0] e_fa, e_fb;
    bit stall;
    #1;
    stall = model_stall();
    e_fa = reset ? 2'b00 : model_fwd(ex_rs1);
    e_fb = reset ? 2'b00 : model_fwd(ex_rs2);
    if (reset)                   e_ctl = 4'b1100;
    else if (halt_seen || ex_halt) e_ctl = 4'b0011;
    else if (ex_redirect)        e_ctl = 4'b1111;
    else if (stall)              e_ctl = 4'b0001;
    else                         e_ctl = 4'b1100;
    check({tag, "/ctl"},   {28'd0, b_pc, b_ifid, b_iff, b_idf}, {28'd0, e_ctl});
    check({tag, "/ctl_s"}, {28'd0, s_pc, s_ifid, s_iff, s_idf}, {28'd0, e_ctl});
    check({tag, "/fwd"},   {28'd0, b_fa, b_fb}, {28'd0, e_fa, e_fb});
    check({tag, "/fwd_s"}, {28'd0, s_fa, s_fb}, {28'd0, e_fa, e_fb});
    @(posedge clk);
    if (reset) begin
      halt_seen = 0; since = 0; cnt_big = 0; cnt_small = 0;
    end else if (halt_seen) begin
      since++;
    end else begin
      if (stall && !ex_redirect) begin
        if (cnt_big < 65535) cnt_big++;
        if (cnt_small < (1 << W_SMALL) - 1) cnt_small++;
      end
      if (ex_halt) begin halt_seen = 1; since = 1; end
    end
    #1;
    check({tag, "/cnt"},   32'(b_cnt), 32'(cnt_big));
    check({tag, "/cnt_s"}, 32'(s_cnt), 32'(cnt_small));
    check({tag, "/halted"},   32'(b_halted), 32'(halt_seen && since >= D_BIG + 1));
    check({tag, "/halted_s"}, 32'(s_halted), 32'(halt_seen && since >= D_SMALL + 1));
  endtask

  task automatic clear_inputs();
    reset = 0; ex_halt = 0; ex_redirect = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
  endtask

  task automatic load_use_inputs();
    clear_inputs();
    ex_rd = 5; ex_regwrite = 1; ex_memread = 1;
    id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 9; id_use_rs2 = 1;
  endtask

  task automatic random_inputs();
    reset       = ($urandom_range(0, 39) == 0);
    ex_halt     = 0;
    ex_redirect = ($urandom_range(0, 3) == 0);
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
    wb_rd  = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
    ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
    mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
  endtask

  initial begin
    int first_big, first_small;

    // Reset with hazard-looking inputs: outputs must show the idle run values.
    load_use_inputs();
    ex_redirect = 1; mem_rd = 5; mem_regwrite = 1; ex_rs1 = 5;
    reset = 1;
    #1;
    check("rst_pc", 32'(b_pc), 32'd1);
    check("rst_flush", 32'({b_iff, b_idf}), 32'd0);
    run_cycle("reset0");
    run_cycle("reset1");
    check("rst_cnt", 32'(b_cnt), 32'd0);

    // Load-use: lw x5 in EX, add reading x5 in ID.
    load_use_inputs();
    #1;
    check("lu_pc", 32'(b_pc), 32'd0);
    check("lu_idf", 32'(b_idf), 32'd1);
    run_cycle("loaduse");
    check("lu_cnt", 32'(b_cnt), 32'd1);

    // x0 guard on both the stall and forwarding paths.
    clear_inputs();
    ex_rd = 0; ex_regwrite = 1; ex_memread = 1; id_rs1 = 0; id_use_rs1 = 1;
    mem_rd = 0; mem_regwrite = 1; ex_rs1 = 0;
    #1;
    check("x0_pc", 32'(b_pc), 32'd1);
    check("x0_fwd", 32'(b_fa), 32'd0);
    run_cycle("x0");

    // Load-use and redirect together: redirect wins, nothing counted.
    load_use_inputs();
    ex_redirect = 1;
    #1;
    check("both_ctl", 32'({b_pc, b_iff, b_idf}), 32'b111);
    run_cycle("both");
    check("both_cnt", 32'(b_cnt), 32'd1);

`ifdef HAZARD_FORWARD_EN
    // Forward priority: EX/MEM over MEM/WB.
    clear_inputs();
    ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1;
    #1;
    check("fwd_mem", 32'(b_fa), 32'b10);
    run_cycle("fwdmem");
    mem_regwrite = 0;
    #1;
    check("fwd_wb", 32'(b_fa), 32'b01);
    run_cycle("fwdwb");
`else
    // No forwarding: a MEM producer stalls for as long as it matches.
    clear_inputs();
    mem_regwrite = 1; mem_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    ex_rs1 = 3; wb_rd = 3; wb_regwrite = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nofwd_pc", 32'(b_pc), 32'd0);
      check("nofwd_sel", 32'({b_fa, b_fb}), 32'd0);
      run_cycle("nofwd");
    end
`endif

    // Saturation of the narrow counter.
    load_use_inputs();
    for (int i = 0; i < 5; i++) run_cycle("sat");
    check("sat_small", 32'(s_cnt), 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      run_cycle("rand");
    end

    // Halt: pulse once, then try to disturb the drained pipeline.
    clear_inputs();
    reset = 1;
    run_cycle("hrst");
    reset = 0;
    ex_halt = 1; ex_redirect = 1;
    first_big = -1; first_small = -1;
    for (int e = 1; e <= 10; e++) begin
      run_cycle("halt");
      if (b_halted && first_big < 0)   first_big = e;
      if (s_halted && first_small < 0) first_small = e;
      load_use_inputs();
      ex_redirect = 1;
      ex_halt = 0;
    end
    check("halt_edges", 32'(first_big), 32'd4);
    check("halt_edges_s", 32'(first_small), 32'd2);

    // Reset during DRAIN aborts to RUN.
    clear_inputs();
    reset = 1;
    run_cycle("drst0");
    reset = 0;
    ex_halt = 1;
    run_cycle("dhalt");
    ex_halt = 0;
    run_cycle("ddrain");
    reset = 1;
    run_cycle("dabort");
    check("abort_halted", 32'(b_halted), 32'd0);
    reset = 0;
    #1;
    check("abort_pc", 32'(b_pc), 32'd1);
    run_cycle("drun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
